seg_scan_latch: RTL

SEG_SCAN_LATCH -- requirements
Module: seg_scan_latch

---
 rtl/seg_pkg.sv | 30 +++
 rtl/bcd7seg.sv | 27 ++
 rtl/seg_scan_latch.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the two-digit scanned seven-segment display:
// FSM state encoding and active-low segment patterns {g,f,e,d,c,b,a}.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_LIVE   = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] AN_OFF    = 2'b11;

  function automatic logic bcd_invalid(input logic [3:0] digit);
    return (digit > 4'd9);
  endfunction

endpackage

// File: rtl/bcd7seg.sv
// Combinational BCD to active-low seven-segment decode; codes above 9 show a dash.
module bcd7seg
  import seg_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  // Pattern lookup for one digit.
  always_comb begin
    o_seg = SEG_DASH;
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_latch.sv
// Latches a two-digit BCD value on load, freezes/unfreezes on a push-button,
// and time-multiplexes the digits onto a shared active-low segment bus.
module seg_scan_latch
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ones_in,
  input  logic [7:0] tens_in,
  input  logic       load,
  input  logic       hold_btn,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frozen,
  output logic       bcd_err
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] PRESC_MAX = CW'(REFRESH_DIV - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_hold_prev;
  logic          w_hold_rise;
  logic [CW-1:0] r_presc;
  logic          r_sel;
  logic          w_wrap;
  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_latch;
  logic [3:0]    r_ones;
  logic [3:0]    r_tens;
  logic [3:0]    w_ones_nxt;
  logic [3:0]    w_tens_nxt;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg_dec;
  logic [6:0]    w_seg_nxt;
  logic [1:0]    w_an_nxt;
  logic [6:0]    r_seg;
  logic [1:0]    r_an;
  logic          r_frozen;
  logic          r_bcd_err;
  logic          w_unused_bits;

  assign w_unused_bits = ^{ones_in[7:4], tens_in[7:4]};

  // Two-flop synchronizer plus one edge-detect flop for the button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_hold_prev <= 1'b0;
    end else begin
      r_sync1     <= hold_btn;
      r_sync2     <= r_sync1;
      r_hold_prev <= r_sync2;
    end
  end

  assign w_hold_rise = r_sync2 & ~r_hold_prev;
  assign w_wrap      = (r_presc == PRESC_MAX);

  // Free-running scan prescaler and digit select, independent of FSM state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
      r_sel   <= 1'b0;
    end else if (w_wrap) begin
      r_presc <= '0;
      r_sel   <= ~r_sel;
    end else begin
      r_presc <= r_presc + CW'(1);
      r_sel   <= r_sel;
    end
  end

  // Next-state logic; a load in FROZEN is dropped even when it coincides with the unfreeze.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (load) begin
          w_state_nxt = ST_LIVE;
          w_latch     = 1'b1;
        end else begin
          w_state_nxt = ST_BLANK;
        end
      end
      ST_LIVE: begin
        w_latch = load;
        if (w_hold_rise) begin
          w_state_nxt = ST_FROZEN;
        end else begin
          w_state_nxt = ST_LIVE;
        end
      end
      ST_FROZEN: begin
        if (w_hold_rise) begin
          w_state_nxt = ST_LIVE;
        end else begin
          w_state_nxt = ST_FROZEN;
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
      end
    endcase
  end

  // Digit latch selection.
  always_comb begin
    w_ones_nxt = r_ones;
    w_tens_nxt = r_tens;
    if (w_latch) begin
      w_ones_nxt = ones_in[3:0];
      w_tens_nxt = tens_in[3:0];
    end else begin
      w_ones_nxt = r_ones;
      w_tens_nxt = r_tens;
    end
  end

  assign w_digit = r_sel ? r_tens : r_ones;

  bcd7seg u_bcd7seg (
    .i_digit (w_digit),
    .o_seg   (w_seg_dec)
  );

  // Display drive; tens anode stays off for a leading zero.
  always_comb begin
    w_seg_nxt = SEG_BLANK;
    w_an_nxt  = AN_OFF;
    if (r_state == ST_BLANK) begin
      w_seg_nxt = SEG_BLANK;
      w_an_nxt  = AN_OFF;
    end else begin
      w_seg_nxt = w_seg_dec;
      if (!r_sel) begin
        w_an_nxt = 2'b10;
      end else if (r_tens == 4'd0) begin
        w_an_nxt = AN_OFF;
      end else begin
        w_an_nxt = 2'b01;
      end
    end
  end

  // State, latched digits and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_BLANK;
      r_ones    <= 4'd0;
      r_tens    <= 4'd0;
      r_seg     <= SEG_BLANK;
      r_an      <= AN_OFF;
      r_frozen  <= 1'b0;
      r_bcd_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ones    <= w_ones_nxt;
      r_tens    <= w_tens_nxt;
      r_seg     <= w_seg_nxt;
      r_an      <= w_an_nxt;
      r_frozen  <= (w_state_nxt == ST_FROZEN);
      r_bcd_err <= bcd_invalid(w_ones_nxt) | bcd_invalid(w_tens_nxt);
    end
  end

  assign seg     = r_seg;
  assign an      = r_an;
  assign frozen  = r_frozen;
  assign bcd_err = r_bcd_err;

endmodule
